// File: rtl/mac_stream.sv
// rtl/mac_stream.sv - pipelined saturating multiply-accumulate engine with stream handshakes
//
// Purpose:
//   Accepts (x, f) operand pairs on a valid/ready stream, multiplies each pair,
//   scales the product by FRAC_W fractional bits, and accumulates FILTER_LEN
//   products into one saturated dot product. The result (optionally ReLU'd)
//   is held on a valid/ready output port until accepted. Output backpressure
//   stalls the whole pipeline.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous flush of pipeline, accumulator and output
//   in_valid_i   operand pair valid
//   in_ready_o   operand pair accepted when in_valid_i & in_ready_o
//   x_data_i     signed input sample
//   f_data_i     signed filter tap
//   out_valid_o  result valid, held until accepted
//   out_ready_i  downstream accepts when out_valid_o & out_ready_i
//   out_data_o   dot-product result
//   tap_idx_o    index of the next product to be accumulated

module mac_stream #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 0,
  parameter int FILTER_LEN = 4,
  parameter int RELU_EN    = 1,
  parameter int TAP_W      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] x_data_i,
  input  logic [DATA_W-1:0] f_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [TAP_W-1:0]  tap_idx_o
);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  out_state_e          state_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                p_valid_q;
  logic [DATA_W-1:0]   p_q;
  logic [DATA_W-1:0]   acc_q;
  logic [TAP_W-1:0]    tap_q;

  logic                stall;
  logic                accept;
  logic                fire;
  logic                last_tap;
  logic                complete;

  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [2*DATA_W-1:0] prod_shift;
  logic                       p_over;
  logic [DATA_W-1:0]          p_sat_d;
  logic [DATA_W:0]            sum_full;
  logic [DATA_W-1:0]          sum_sat;
  logic [DATA_W-1:0]          result_d;

  // A pending, unaccepted result freezes everything upstream of it.
  assign stall      = out_valid_q & ~out_ready_i;
  assign in_ready_o = rst_ni & ~stall & ~clear_i;
  assign accept     = in_valid_i & in_ready_o;
  assign fire       = p_valid_q & ~stall;
  assign last_tap   = (tap_q == TAP_W'(FILTER_LEN - 1));
  assign complete   = fire & last_tap;

  always_comb begin
    prod_full  = $signed(x_data_i) * $signed(f_data_i);
    prod_shift = prod_full >>> FRAC_W;
    // The shifted product fits in DATA_W bits only if its top DATA_W+1 bits
    // are a pure sign extension.
    p_over  = ~((&prod_shift[2*DATA_W-1:DATA_W-1]) | ~(|prod_shift[2*DATA_W-1:DATA_W-1]));
    p_sat_d = p_over ? {prod_shift[2*DATA_W-1], {(DATA_W-1){~prod_shift[2*DATA_W-1]}}}
                     : prod_shift[DATA_W-1:0];

    // One guard bit is enough to detect overflow of a two-operand add.
    sum_full = {acc_q[DATA_W-1], acc_q} + {p_q[DATA_W-1], p_q};
    sum_sat  = (sum_full[DATA_W] != sum_full[DATA_W-1])
             ? {sum_full[DATA_W], {(DATA_W-1){~sum_full[DATA_W]}}}
             : sum_full[DATA_W-1:0];

    result_d = sum_sat;
    if ((RELU_EN != 0) && sum_sat[DATA_W-1]) begin
      result_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= OUT_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      p_valid_q   <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      tap_q       <= '0;
    end else if (clear_i) begin
      state_q     <= OUT_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      p_valid_q   <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      tap_q       <= '0;
    end else begin
      // Product stage: holds its contents while stalled.
      if (!stall) begin
        p_valid_q <= accept;
        if (accept) begin
          p_q <= p_sat_d;
        end
      end

      // Accumulate stage: the last tap restarts the window on the same edge.
      if (fire) begin
        if (last_tap) begin
          acc_q      <= '0;
          tap_q      <= '0;
          out_data_q <= result_d;
        end else begin
          acc_q <= sum_sat;
          tap_q <= tap_q + TAP_W'(1);
        end
      end

      // Output holding register. A completion implies no stall, so any
      // previous result is being accepted on the same edge.
      case (state_q)
        OUT_EMPTY: begin
          if (complete) begin
            state_q     <= OUT_FULL;
            out_valid_q <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (complete) begin
            state_q     <= OUT_FULL;
            out_valid_q <= 1'b1;
          end else if (out_ready_i) begin
            state_q     <= OUT_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign tap_idx_o   = tap_q;

endmodule

// File: tb/tb_mac_stream.sv
// tb/tb_mac_stream.sv - self-checking bench for mac_stream

module tb_mac_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] x;
  logic [15:0] f;
  logic        out_ready;

  logic        in_ready_a, out_valid_a;
  logic [15:0] out_data_a;
  logic [1:0]  tap_a;
  logic        in_ready_b, out_valid_b;
  logic [15:0] out_data_b;
  logic [1:0]  tap_b;

  logic        c_in_valid;
  logic [15:0] c_x;
  logic [15:0] c_f;
  logic        c_out_ready;
  logic        c_in_ready, c_out_valid;
  logic [15:0] c_out_data;
  logic [0:0]  c_tap;

  mac_stream #(.DATA_W(16), .FRAC_W(0), .FILTER_LEN(4), .RELU_EN(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .x_data_i(x), .f_data_i(f),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_data_o(out_data_a), .tap_idx_o(tap_a)
  );

  mac_stream #(.DATA_W(16), .FRAC_W(0), .FILTER_LEN(4), .RELU_EN(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .x_data_i(x), .f_data_i(f),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_data_o(out_data_b), .tap_idx_o(tap_b)
  );

  mac_stream #(.DATA_W(16), .FRAC_W(8), .FILTER_LEN(1), .RELU_EN(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .x_data_i(c_x), .f_data_i(c_f),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
    .out_data_o(c_out_data), .tap_idx_o(c_tap)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic for the FILTER_LEN=4, FRAC_W=0 configuration.
  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int scaled_prod(input int xv, input int fv, input int frac);
    longint full;
    full = longint'(xv) * longint'(fv);
    return sat16(full >>> frac);
  endfunction

  int m_acc = 0;
  int m_cnt = 0;
  int exp_q[$];

  task automatic model_accept(input logic [15:0] xv, input logic [15:0] fv);
    m_acc = sat16(longint'(m_acc) + longint'(scaled_prod(int'($signed(xv)), int'($signed(fv)), 0)));
    m_cnt++;
    if (m_cnt == 4) begin
      exp_q.push_back(m_acc);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom % 5)
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'($urandom_range(0, 15)) - 16'd8;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ab(input logic [15:0] xv, input logic [15:0] fv);
    in_valid = 1'b1;
    x = xv;
    f = fv;
    @(negedge clk);
    chk("send_ab_ready", {15'd0, in_ready_a}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [15:0] xv, input logic [15:0] fv);
    c_in_valid = 1'b1;
    c_x = xv;
    c_f = fv;
    @(negedge clk);
    chk("send_c_ready", {15'd0, c_in_ready}, 16'd1);
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
  endtask

  logic        hs_in, hs_out;
  logic        hold_prev;
  logic [15:0] held_data;
  int          e;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; x = '0; f = '0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_x = '0; c_f = '0; c_out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready",  {15'd0, in_ready_a},  16'd0);
    chk("rst_out_valid", {15'd0, out_valid_a}, 16'd0);
    chk("rst_out_data",  out_data_a,           16'd0);
    chk("rst_tap",       {14'd0, tap_a},       16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_a", {15'd0, in_ready_a}, 16'd1);
    chk("rel_in_ready_c", {15'd0, c_in_ready}, 16'd1);
    cyc();

    // x=1..4, f=2: 20, visible two cycles after the last accept
    for (int i = 1; i <= 4; i++) send_ab(16'(i), 16'd2);
    chk("t1_latency_early", {15'd0, out_valid_a}, 16'd0);
    cyc();
    chk("t1_valid",  {15'd0, out_valid_a}, 16'd1);
    chk("t1_data_a", out_data_a, 16'd20);
    chk("t1_data_b", out_data_b, 16'd20);
    cyc();
    chk("t1_taken", {15'd0, out_valid_a}, 16'd0);

    // -3*5 four times: ReLU gives 0, pass-through gives -60
    for (int i = 0; i < 4; i++) send_ab(16'hFFFD, 16'd5);
    cyc();
    chk("t2_relu",    out_data_a, 16'd0);
    chk("t2_norelu",  out_data_b, 16'hFFC4);
    cyc();

    // Positive and negative saturation at product and accumulator
    for (int i = 0; i < 4; i++) send_ab(16'h7FFF, 16'h7FFF);
    cyc();
    chk("t3_pos_sat", out_data_b, 16'h7FFF);
    chk("t3_pos_a",   out_data_a, 16'h7FFF);
    cyc();
    for (int i = 0; i < 4; i++) send_ab(16'h8000, 16'h7FFF);
    cyc();
    chk("t3_neg_sat", out_data_b, 16'h8000);
    chk("t3_neg_relu", out_data_a, 16'h0000);
    cyc();

    // Backpressure: first result held, next window's pair must not be lost
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_ab(16'd1, 16'd1);
    send_ab(16'd2, 16'd3);
    in_valid = 1'b1; x = 16'd9; f = 16'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_ready", {15'd0, in_ready_a},  16'd0);
      chk("t5_stall_valid", {15'd0, out_valid_a}, 16'd1);
      chk("t5_stall_data",  out_data_a,           16'd4);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("t5_released", {15'd0, out_valid_a}, 16'd0);
    chk("t5_tap",      {14'd0, tap_a},       16'd1);
    for (int i = 0; i < 3; i++) send_ab(16'd2, 16'd3);
    cyc();
    chk("t5_second_valid", {15'd0, out_valid_a}, 16'd1);
    chk("t5_second_data",  out_data_a,           16'd24);
    cyc();

    // Clear after two taps
    send_ab(16'd5, 16'd5);
    send_ab(16'd5, 16'd5);
    chk("t6_tap_before", {14'd0, tap_a}, 16'd1);
    clear = 1'b1; in_valid = 1'b1; x = 16'd100; f = 16'd100;
    @(negedge clk);
    chk("t6_clear_ready", {15'd0, in_ready_a}, 16'd0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("t6_clear_tap",   {14'd0, tap_a},       16'd0);
    chk("t6_clear_valid", {15'd0, out_valid_a}, 16'd0);
    for (int i = 0; i < 4; i++) send_ab(16'd1, 16'd3);
    cyc();
    chk("t6_after_clear", out_data_a, 16'd12);
    cyc();

    // Async reset with a pending result and a partial window
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_ab(16'd1, 16'd1);
    send_ab(16'd2, 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {15'd0, out_valid_a}, 16'd0);
    chk("t6_rst_data",  out_data_a,           16'd0);
    chk("t6_rst_tap",   {14'd0, tap_a},       16'd0);
    chk("t6_rst_ready", {15'd0, in_ready_a},  16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_ab(16'd1, 16'd5);
    cyc();
    chk("t6_rst_result_valid", {15'd0, out_valid_a}, 16'd1);
    chk("t6_rst_result",       out_data_a,           16'd20);
    cyc();

    // Fixed-point scaling, single-tap windows
    send_c(16'h0180, 16'h0200);
    cyc();
    chk("t4_c_valid", {15'd0, c_out_valid}, 16'd1);
    chk("t4_c_data",  c_out_data,           16'h0300);
    chk("t4_c_tap",   {15'd0, c_tap},       16'd0);
    send_c(16'hFFFF, 16'h0001);
    cyc();
    chk("t4_c_neg_relu", c_out_data, 16'h0000);
    send_c(16'h7FFF, 16'h7FFF);
    cyc();
    chk("t4_c_sat", c_out_data, 16'h7FFF);
    cyc();

    // Randomized traffic against the window model
    m_acc = 0; m_cnt = 0; exp_q.delete();
    hold_prev = 1'b0; held_data = '0;
    for (int cyc_n = 0; cyc_n < 600; cyc_n++) begin
      in_valid  = ($urandom % 4) != 0;
      x         = rnd16();
      f         = rnd16();
      out_ready = ($urandom % 10) < 7;
      clear     = ($urandom % 60) == 0;
      @(negedge clk);
      hs_in  = in_valid & in_ready_a;
      hs_out = out_valid_a & out_ready;
      chk("rnd_in_ready", {15'd0, in_ready_a}, {15'd0, ~(out_valid_a & ~out_ready) & ~clear});
      if (hold_prev) begin
        chk("rnd_hold_valid", {15'd0, out_valid_a}, 16'd1);
        chk("rnd_hold_data",  out_data_a,           held_data);
      end
      if (hs_out) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_result", {15'd0, out_valid_a}, 16'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_data_relu",   out_data_a, (e < 0) ? 16'd0 : 16'(e));
          chk("rnd_data_norelu", out_data_b, 16'(e));
        end
      end
      if (clear) begin
        exp_q.delete();
        m_acc = 0;
        m_cnt = 0;
      end else if (hs_in) begin
        model_accept(x, f);
      end
      hold_prev = out_valid_a & ~out_ready & ~clear;
      held_data = out_data_a;
      @(posedge clk);
      #1;
    end

    // Drain remaining results within a bounded number of cycles
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_a) begin
        if (exp_q.size() == 0) begin
          chk("drain_spurious_result", {15'd0, out_valid_a}, 16'd0);
        end else begin
          e = exp_q.pop_front();
          chk("drain_data_relu",   out_data_a, (e < 0) ? 16'd0 : 16'(e));
          chk("drain_data_norelu", out_data_b, 16'(e));
        end
      end
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
